// File: rtl/gmii_xgmii_frame_packer.sv
// gmii_xgmii_frame_packer
// Store-and-forward packer: collects a byte-wide GMII receive stream (qualified
// by gmii_ce) into LANES-byte XGMII words. Complete frames are buffered in a
// word FIFO, then emitted contiguously with START/TERMINATE/ERROR control
// characters and at least IPG_WORDS all-idle words after every TERMINATE.
// Ports:
//   xgmii_clk, sys_rst_n        : clock, synchronous active-low reset
//   gmii_ce/dv/er/rxd           : byte strobe, frame valid, byte error, byte
//   xgmii_rxd/xgmii_rxc         : packed output word and per-lane control flags
//   frame_cnt/drop_cnt          : emitted / dropped frame counters (wrapping)
//   fifo_ovf                    : one-cycle pulse when a frame is dropped for FIFO full
module gmii_xgmii_frame_packer #(
    parameter int unsigned LANES               = 8,
    parameter int unsigned FIFO_AW             = 8,
    parameter int unsigned FRAME_MAX_BIT_WIDTH = 11,
    parameter int unsigned IPG_WORDS           = 1
) (
    input  logic                 xgmii_clk,
    input  logic                 sys_rst_n,
    input  logic                 gmii_ce,
    input  logic                 gmii_dv,
    input  logic                 gmii_er,
    input  logic [7:0]           gmii_rxd,
    output logic [8*LANES-1:0]   xgmii_rxd,
    output logic [LANES-1:0]     xgmii_rxc,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          drop_cnt,
    output logic                 fifo_ovf
);

    localparam int unsigned DW        = 8 * LANES;
    localparam int unsigned LW        = $clog2(LANES);
    localparam int unsigned PW        = FIFO_AW + 1;
    localparam int unsigned DEPTH     = 2 ** FIFO_AW;
    localparam int unsigned BW        = FRAME_MAX_BIT_WIDTH;
    localparam int unsigned FRAME_MAX = (2 ** BW) - 1;
    localparam int unsigned IW        = 4;
    localparam int unsigned MW        = DW + LANES;

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERR   = 8'hFE;

    typedef enum logic [1:0] {W_WAIT, W_IDLE, W_FRAME, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_SEND, R_IPG} rstate_t;

    // writer state
    wstate_t           wst_q, wst_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [LANES-1:0]  wctrl_q, wctrl_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     wr_commit_q, wr_commit_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              ovf_q, ovf_d;

    // reader state
    rstate_t           rst_q, rst_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     pend_q, pend_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [IW-1:0]     ipg_q, ipg_d;
    logic              ram_vld_q;
    logic [MW-1:0]     ram_q;
    logic [DW-1:0]     out_data_q;
    logic [LANES-1:0]  out_ctrl_q;

    // storage: data+ctrl RAM and a per-word end-of-frame flag
    logic [MW-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]  last_mem;

    logic              wr_en_c, wr_last_c, commit_c, rd_en_c, dec_c, full_c;
    logic [DW-1:0]     wr_data_c, byte_data_c, term_data_c;
    logic [LANES-1:0]  wr_ctrl_c, byte_ctrl_c, term_ctrl_c;

    assign full_c = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));

    // Candidate words: current byte dropped into lane_q, or TERMINATE at lane_q
    // with idle fill above it (lane_q==0 yields the stand-alone FD+07s word).
    always_comb begin
        byte_data_c = wdata_q;
        byte_ctrl_c = wctrl_q;
        term_data_c = wdata_q;
        term_ctrl_c = wctrl_q;
        for (int i = 0; i < LANES; i++) begin
            if (LW'(i) == lane_q) begin
                byte_data_c[8*i +: 8] = gmii_er ? C_ERR : gmii_rxd;
                byte_ctrl_c[i]        = gmii_er;
                term_data_c[8*i +: 8] = C_TERM;
                term_ctrl_c[i]        = 1'b1;
            end else if (LW'(i) > lane_q) begin
                term_data_c[8*i +: 8] = C_IDLE;
                term_ctrl_c[i]        = 1'b1;
            end
        end
    end

    // Writer FSM next-state and FIFO write control
    always_comb begin
        wst_d       = wst_q;
        wdata_d     = wdata_q;
        wctrl_d     = wctrl_q;
        lane_d      = lane_q;
        bcnt_d      = bcnt_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_d       = 1'b0;
        wr_en_c     = 1'b0;
        wr_last_c   = 1'b0;
        commit_c    = 1'b0;
        wr_data_c   = byte_data_c;
        wr_ctrl_c   = byte_ctrl_c;
        if (gmii_ce) begin
            case (wst_q)
                W_WAIT: begin
                    if (!gmii_dv) wst_d = W_IDLE;
                end
                W_IDLE: begin
                    if (gmii_dv) begin
                        wdata_d       = {LANES{C_IDLE}};
                        wdata_d[7:0]  = C_START;
                        wctrl_d       = '0;
                        wctrl_d[0]    = 1'b1;
                        lane_d        = LW'(1);
                        bcnt_d        = BW'(1);
                        wst_d         = W_FRAME;
                    end
                end
                W_FRAME: begin
                    if (gmii_dv) begin
                        if (bcnt_q == BW'(FRAME_MAX)) begin
                            wst_d = W_DROP;
                        end else begin
                            bcnt_d  = bcnt_q + BW'(1);
                            wdata_d = byte_data_c;
                            wctrl_d = byte_ctrl_c;
                            if (lane_q == LW'(LANES - 1)) begin
                                if (full_c) begin
                                    ovf_d = 1'b1;
                                    wst_d = W_DROP;
                                end else begin
                                    wr_en_c  = 1'b1;
                                    wr_ptr_d = wr_ptr_q + PW'(1);
                                    lane_d   = '0;
                                end
                            end else begin
                                lane_d = lane_q + LW'(1);
                            end
                        end
                    end else begin
                        wr_data_c = term_data_c;
                        wr_ctrl_c = term_ctrl_c;
                        // dv already low, so a full FIFO here ends the drop at once
                        if (full_c) begin
                            ovf_d      = 1'b1;
                            wr_ptr_d   = wr_commit_q;
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end else begin
                            wr_en_c     = 1'b1;
                            wr_last_c   = 1'b1;
                            commit_c    = 1'b1;
                            wr_ptr_d    = wr_ptr_q + PW'(1);
                            wr_commit_d = wr_ptr_q + PW'(1);
                        end
                        wst_d = W_IDLE;
                    end
                end
                W_DROP: begin
                    if (!gmii_dv) begin
                        wr_ptr_d   = wr_commit_q;
                        drop_cnt_d = drop_cnt_q + 16'd1;
                        wst_d      = W_IDLE;
                    end
                end
                default: wst_d = W_WAIT;
            endcase
        end
    end

    // Reader FSM: whole committed frames only, one word per cycle
    always_comb begin
        rst_d       = rst_q;
        rd_ptr_d    = rd_ptr_q;
        frame_cnt_d = frame_cnt_q;
        ipg_d       = ipg_q;
        rd_en_c     = 1'b0;
        dec_c       = 1'b0;
        case (rst_q)
            R_IDLE: begin
                if (pend_q != '0) rst_d = R_SEND;
            end
            R_SEND: begin
                rd_en_c  = 1'b1;
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (last_mem[rd_ptr_q[FIFO_AW-1:0]]) begin
                    dec_c       = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    ipg_d       = IW'(IPG_WORDS - 1);
                    rst_d       = R_IPG;
                end
            end
            R_IPG: begin
                if (ipg_q == '0) begin
                    rst_d = (pend_q != '0) ? R_SEND : R_IDLE;
                end else begin
                    ipg_d = ipg_q - IW'(1);
                end
            end
            default: rst_d = R_IDLE;
        endcase
        // simultaneous commit and decrement cancel out
        pend_d = pend_q;
        if (commit_c && !dec_c) pend_d = pend_q + PW'(1);
        else if (!commit_c && dec_c) pend_d = pend_q - PW'(1);
    end

    // Word RAM: synchronous write, registered read
    always_ff @(posedge xgmii_clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q[FIFO_AW-1:0]]      <= {wr_ctrl_c, wr_data_c};
            last_mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_last_c;
        end
        if (rd_en_c) ram_q <= mem[rd_ptr_q[FIFO_AW-1:0]];
    end

    // State, counters and output registers
    always_ff @(posedge xgmii_clk) begin
        if (!sys_rst_n) begin
            wst_q       <= W_WAIT;
            wdata_q     <= '0;
            wctrl_q     <= '0;
            lane_q      <= '0;
            bcnt_q      <= '0;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            rst_q       <= R_IDLE;
            rd_ptr_q    <= '0;
            pend_q      <= '0;
            frame_cnt_q <= '0;
            ipg_q       <= '0;
            ram_vld_q   <= 1'b0;
            out_data_q  <= {LANES{C_IDLE}};
            out_ctrl_q  <= '1;
        end else begin
            wst_q       <= wst_d;
            wdata_q     <= wdata_d;
            wctrl_q     <= wctrl_d;
            lane_q      <= lane_d;
            bcnt_q      <= bcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_q       <= ovf_d;
            rst_q       <= rst_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
            ipg_q       <= ipg_d;
            ram_vld_q   <= rd_en_c;
            if (ram_vld_q) begin
                out_data_q <= ram_q[DW-1:0];
                out_ctrl_q <= ram_q[MW-1:DW];
            end else begin
                out_data_q <= {LANES{C_IDLE}};
                out_ctrl_q <= '1;
            end
        end
    end

    assign xgmii_rxd = out_data_q;
    assign xgmii_rxc = out_ctrl_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign fifo_ovf  = ovf_q;

endmodule

// File: tb/tb_gmii_xgmii_frame_packer.sv
// Directed bench for gmii_xgmii_frame_packer. Three instances share the input
// stream: default parameters (a), IPG_WORDS=2 (b), FIFO_AW=4 (c).
module tb_gmii_xgmii_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, dv, er;
    logic [7:0]  rxd;

    logic [63:0] a_rxd, b_rxd, c_rxd;
    logic [7:0]  a_rxc, b_rxc, c_rxc;
    logic [15:0] a_fcnt, b_fcnt, c_fcnt, a_dcnt, b_dcnt, c_dcnt;
    logic        a_ovf, b_ovf, c_ovf;

    int total = 0;
    int bad   = 0;

    logic [63:0] qa_d[$], qb_d[$], qc_d[$];
    logic [7:0]  qa_c[$], qb_c[$], qc_c[$];
    int          ovf_a = 0, ovf_c = 0;
    logic [7:0]  fb[$];

    always #5 clk = ~clk;

    gmii_xgmii_frame_packer #(.LANES(8), .FIFO_AW(8), .FRAME_MAX_BIT_WIDTH(11), .IPG_WORDS(1)) dut_a (
        .xgmii_clk(clk), .sys_rst_n(rst_n), .gmii_ce(ce), .gmii_dv(dv), .gmii_er(er), .gmii_rxd(rxd),
        .xgmii_rxd(a_rxd), .xgmii_rxc(a_rxc), .frame_cnt(a_fcnt), .drop_cnt(a_dcnt), .fifo_ovf(a_ovf));

    gmii_xgmii_frame_packer #(.LANES(8), .FIFO_AW(8), .FRAME_MAX_BIT_WIDTH(11), .IPG_WORDS(2)) dut_b (
        .xgmii_clk(clk), .sys_rst_n(rst_n), .gmii_ce(ce), .gmii_dv(dv), .gmii_er(er), .gmii_rxd(rxd),
        .xgmii_rxd(b_rxd), .xgmii_rxc(b_rxc), .frame_cnt(b_fcnt), .drop_cnt(b_dcnt), .fifo_ovf(b_ovf));

    gmii_xgmii_frame_packer #(.LANES(8), .FIFO_AW(4), .FRAME_MAX_BIT_WIDTH(11), .IPG_WORDS(1)) dut_c (
        .xgmii_clk(clk), .sys_rst_n(rst_n), .gmii_ce(ce), .gmii_dv(dv), .gmii_er(er), .gmii_rxd(rxd),
        .xgmii_rxd(c_rxd), .xgmii_rxc(c_rxc), .frame_cnt(c_fcnt), .drop_cnt(c_dcnt), .fifo_ovf(c_ovf));

    function automatic bit is_idle(input logic [63:0] d, input logic [7:0] c);
        return (d == 64'h0707070707070707) && (c == 8'hFF);
    endfunction

    // output capture on the falling edge
    always @(negedge clk) begin
        if (!is_idle(a_rxd, a_rxc)) begin qa_d.push_back(a_rxd); qa_c.push_back(a_rxc); end
        if (!is_idle(c_rxd, c_rxc)) begin qc_d.push_back(c_rxd); qc_c.push_back(c_rxc); end
        qb_d.push_back(b_rxd);
        qb_c.push_back(b_rxc);
        if (a_ovf) ovf_a++;
        if (c_ovf) ovf_c++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ce = 1'b1; dv = 1'b0; er = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_q();
        qa_d.delete(); qa_c.delete(); qb_d.delete(); qb_c.delete(); qc_d.delete(); qc_c.delete();
    endtask

    task automatic preamble();
        fb.delete();
        repeat (7) fb.push_back(8'h55);
        fb.push_back(8'hD5);
    endtask

    task automatic build12();
        preamble();
        fb.push_back(8'hAA); fb.push_back(8'hBB); fb.push_back(8'hCC); fb.push_back(8'hDD);
    endtask

    task automatic build_count(input int n_data);
        preamble();
        for (int i = 0; i < n_data; i++) fb.push_back(8'(i));
    endtask

    // gap = number of ce=0 cycles inserted before every strobed byte
    task automatic send_frame(input int err_idx, input int gap);
        for (int i = 0; i < fb.size(); i++) begin
            repeat (gap) begin ce = 1'b0; tick(); end
            ce = 1'b1; dv = 1'b1; rxd = fb[i]; er = (i == err_idx);
            tick();
        end
        repeat (gap) begin ce = 1'b0; tick(); end
        ce = 1'b1; dv = 1'b0; er = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (a_rxd !== 64'h0707070707070707) begin bad++; $display("FAIL reset_rxd got=%h exp=0707070707070707", a_rxd); end
        total++; if (a_rxc !== 8'hFF) begin bad++; $display("FAIL reset_rxc got=%h exp=ff", a_rxc); end
        total++; if (a_fcnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", a_fcnt); end
        total++; if (a_dcnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", a_dcnt); end
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset_fifo_ovf got=%b exp=0", a_ovf); end
        tick();
        idle(4);
    endtask

    task automatic test_basic();
        logic [15:0] f0;
        logic [63:0] w0, w1;
        logic [7:0]  c0, c1;
        clear_q(); f0 = a_fcnt;
        build12(); send_frame(-1, 0); idle(20);
        total++; if (qa_d.size() !== 2) begin bad++; $display("FAIL basic_words got=%0d exp=2", qa_d.size()); end
        w0 = (qa_d.size() > 0) ? qa_d[0] : '0; c0 = (qa_c.size() > 0) ? qa_c[0] : '0;
        w1 = (qa_d.size() > 1) ? qa_d[1] : '0; c1 = (qa_c.size() > 1) ? qa_c[1] : '0;
        total++; if (w0 !== 64'hD5555555555555FB) begin bad++; $display("FAIL basic_w0 got=%h exp=d5555555555555fb", w0); end
        total++; if (c0 !== 8'h01) begin bad++; $display("FAIL basic_c0 got=%h exp=01", c0); end
        total++; if (w1 !== 64'h070707FDDDCCBBAA) begin bad++; $display("FAIL basic_w1 got=%h exp=070707fdddccbbaa", w1); end
        total++; if (c1 !== 8'hF0) begin bad++; $display("FAIL basic_c1 got=%h exp=f0", c1); end
        total++; if (a_fcnt - f0 !== 16'd1) begin bad++; $display("FAIL basic_frame_cnt got=%0d exp=1", a_fcnt - f0); end
    endtask

    task automatic test_aligned_terminate();
        logic [63:0] w1, w2;
        logic [7:0]  c2;
        clear_q();
        preamble();
        for (int i = 1; i <= 8; i++) fb.push_back(8'(i));
        send_frame(-1, 0); idle(20);
        total++; if (qa_d.size() !== 3) begin bad++; $display("FAIL aligned_words got=%0d exp=3", qa_d.size()); end
        w1 = (qa_d.size() > 1) ? qa_d[1] : '0;
        w2 = (qa_d.size() > 2) ? qa_d[2] : '0; c2 = (qa_c.size() > 2) ? qa_c[2] : '0;
        total++; if (w1 !== 64'h0807060504030201) begin bad++; $display("FAIL aligned_w1 got=%h exp=0807060504030201", w1); end
        total++; if (w2 !== 64'h07070707070707FD) begin bad++; $display("FAIL aligned_term got=%h exp=07070707070707fd", w2); end
        total++; if (c2 !== 8'hFF) begin bad++; $display("FAIL aligned_term_c got=%h exp=ff", c2); end
    endtask

    task automatic test_error_byte();
        logic [15:0] f0;
        logic [63:0] w1;
        logic [7:0]  c1;
        clear_q(); f0 = a_fcnt;
        build12(); send_frame(9, 0); idle(20);
        w1 = (qa_d.size() > 1) ? qa_d[1] : '0; c1 = (qa_c.size() > 1) ? qa_c[1] : '0;
        total++; if (w1 !== 64'h070707FDDDCCFEAA) begin bad++; $display("FAIL err_w1 got=%h exp=070707fdddccfeaa", w1); end
        total++; if (c1 !== 8'hF2) begin bad++; $display("FAIL err_c1 got=%h exp=f2", c1); end
        total++; if (a_fcnt - f0 !== 16'd1) begin bad++; $display("FAIL err_frame_cnt got=%0d exp=1", a_fcnt - f0); end
    endtask

    // 9-byte frame then a 2-byte frame; the second commits while the first is draining
    task automatic test_back_to_back();
        logic [15:0] f0;
        int s, gap;
        logic [63:0] wa0, wa1, wb;
        clear_q(); f0 = b_fcnt;
        preamble(); fb.push_back(8'hAA); send_frame(-1, 0);
        fb.delete(); fb.push_back(8'h55); fb.push_back(8'h11); send_frame(-1, 0);
        idle(20);
        s = 0;
        while (s < qb_d.size() && is_idle(qb_d[s], qb_c[s])) s++;
        wa0 = (s < qb_d.size()) ? qb_d[s] : '0;
        wa1 = (s + 1 < qb_d.size()) ? qb_d[s+1] : '0;
        gap = 0;
        while (s + 2 + gap < qb_d.size() && is_idle(qb_d[s+2+gap], qb_c[s+2+gap])) gap++;
        wb = (s + 2 + gap < qb_d.size()) ? qb_d[s+2+gap] : '0;
        total++; if (wa0 !== 64'hD5555555555555FB) begin bad++; $display("FAIL b2b_a0 got=%h exp=d5555555555555fb", wa0); end
        total++; if (wa1 !== 64'h070707070707FDAA) begin bad++; $display("FAIL b2b_a1 got=%h exp=070707070707fdaa", wa1); end
        total++; if (gap !== 2) begin bad++; $display("FAIL b2b_ipg got=%0d exp=2", gap); end
        total++; if (wb !== 64'h0707070707FD11FB) begin bad++; $display("FAIL b2b_b got=%h exp=0707070707fd11fb", wb); end
        total++; if (b_fcnt - f0 !== 16'd2) begin bad++; $display("FAIL b2b_frame_cnt got=%0d exp=2", b_fcnt - f0); end
    endtask

    task automatic test_oversize();
        logic [15:0] f0, d0;
        int o0;
        logic [63:0] e;
        clear_q(); f0 = a_fcnt; d0 = a_dcnt; o0 = ovf_a;
        build_count(2092); send_frame(-1, 0); idle(20);
        total++; if (qa_d.size() !== 0) begin bad++; $display("FAIL over_output got=%0d exp=0", qa_d.size()); end
        total++; if (a_dcnt - d0 !== 16'd1) begin bad++; $display("FAIL over_drop_cnt got=%0d exp=1", a_dcnt - d0); end
        total++; if (ovf_a - o0 !== 0) begin bad++; $display("FAIL over_fifo_ovf got=%0d exp=0", ovf_a - o0); end
        build_count(56); send_frame(-1, 0); idle(30);
        total++; if (qa_d.size() !== 9) begin bad++; $display("FAIL over_next_words got=%0d exp=9", qa_d.size()); end
        for (int k = 1; k <= 7; k++) begin
            for (int j = 0; j < 8; j++) e[8*j +: 8] = 8'(8 * (k - 1) + j);
            total++;
            if (k >= qa_d.size() || qa_d[k] !== e) begin
                bad++; $display("FAIL over_next_w%0d got=%h exp=%h", k, (k < qa_d.size()) ? qa_d[k] : 64'h0, e);
            end
        end
        e = (qa_d.size() > 8) ? qa_d[8] : '0;
        total++; if (e !== 64'h07070707070707FD) begin bad++; $display("FAIL over_next_term got=%h exp=07070707070707fd", e); end
        total++; if (a_fcnt - f0 !== 16'd1) begin bad++; $display("FAIL over_frame_cnt got=%0d exp=1", a_fcnt - f0); end
    endtask

    task automatic test_fifo_full();
        logic [15:0] f0, d0;
        int o0;
        logic [63:0] w1, w7;
        logic [7:0]  c7;
        clear_q(); f0 = c_fcnt; d0 = c_dcnt; o0 = ovf_c;
        build_count(192); send_frame(-1, 0); idle(20);
        total++; if (ovf_c - o0 !== 1) begin bad++; $display("FAIL full_ovf_pulses got=%0d exp=1", ovf_c - o0); end
        total++; if (c_dcnt - d0 !== 16'd1) begin bad++; $display("FAIL full_drop_cnt got=%0d exp=1", c_dcnt - d0); end
        total++; if (qc_d.size() !== 0) begin bad++; $display("FAIL full_output got=%0d exp=0", qc_d.size()); end
        build_count(52); send_frame(-1, 0); idle(30);
        total++; if (qc_d.size() !== 8) begin bad++; $display("FAIL full_next_words got=%0d exp=8", qc_d.size()); end
        w1 = (qc_d.size() > 1) ? qc_d[1] : '0;
        w7 = (qc_d.size() > 7) ? qc_d[7] : '0; c7 = (qc_c.size() > 7) ? qc_c[7] : '0;
        total++; if (w1 !== 64'h0706050403020100) begin bad++; $display("FAIL full_next_w1 got=%h exp=0706050403020100", w1); end
        total++; if (w7 !== 64'h070707FD33323130) begin bad++; $display("FAIL full_next_w7 got=%h exp=070707fd33323130", w7); end
        total++; if (c7 !== 8'hF0) begin bad++; $display("FAIL full_next_c7 got=%h exp=f0", c7); end
        total++; if (c_fcnt - f0 !== 16'd1) begin bad++; $display("FAIL full_frame_cnt got=%0d exp=1", c_fcnt - f0); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] w0, w1;
        logic [7:0]  c1;
        clear_q();
        ce = 1'b1; dv = 1'b1; er = 1'b0; rxd = 8'h55;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        total++; if (!is_idle(a_rxd, a_rxc)) begin bad++; $display("FAIL rstmid_idle got=%h/%h exp=idle", a_rxd, a_rxc); end
        tick();
        rst_n = 1'b1;
        clear_q();
        for (int i = 0; i < 6; i++) begin rxd = 8'(8'hA0 + i); tick(); end
        idle(20);
        total++; if (qa_d.size() !== 0) begin bad++; $display("FAIL rstmid_output got=%0d exp=0", qa_d.size()); end
        total++; if (a_dcnt !== 16'd0) begin bad++; $display("FAIL rstmid_drop_cnt got=%0d exp=0", a_dcnt); end
        build12(); send_frame(-1, 2); idle(20);
        total++; if (qa_d.size() !== 2) begin bad++; $display("FAIL ce3_words got=%0d exp=2", qa_d.size()); end
        w0 = (qa_d.size() > 0) ? qa_d[0] : '0;
        w1 = (qa_d.size() > 1) ? qa_d[1] : '0; c1 = (qa_c.size() > 1) ? qa_c[1] : '0;
        total++; if (w0 !== 64'hD5555555555555FB) begin bad++; $display("FAIL ce3_w0 got=%h exp=d5555555555555fb", w0); end
        total++; if (w1 !== 64'h070707FDDDCCBBAA) begin bad++; $display("FAIL ce3_w1 got=%h exp=070707fdddccbbaa", w1); end
        total++; if (c1 !== 8'hF0) begin bad++; $display("FAIL ce3_c1 got=%h exp=f0", c1); end
        total++; if (a_fcnt !== 16'd1) begin bad++; $display("FAIL ce3_frame_cnt got=%0d exp=1", a_fcnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aligned_terminate();
        test_error_byte();
        test_back_to_back();
        test_oversize();
        test_fifo_full();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
